// File: rtl/control_decode_stage.sv
// ID-stage decoder for the RV32I pipeline, registered into the ID/EX control
// register, with load-use hazard detection and an illegal-instruction counter.
module control_decode_stage #(
  parameter int ENABLE_M = 0,
  parameter int ALU_OP_W = 5,
  parameter int CNT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [31:0]         i_inst,
  input  logic                i_id_vld,
  input  logic                i_stall,
  input  logic                i_flush,
  output logic                o_hazard_stall,
  output logic                o_ex_vld,
  output logic                o_ex_insn_vld,
  output logic                o_ex_rd_wren,
  output logic                o_ex_mem_wren,
  output logic                o_ex_mem_rden,
  output logic                o_ex_br_un,
  output logic                o_ex_opa_sel,
  output logic                o_ex_opb_sel,
  output logic [ALU_OP_W-1:0] o_ex_alu_op,
  output logic [1:0]          o_ex_wb_sel,
  output logic                o_ex_is_branch,
  output logic                o_ex_is_jump,
  output logic [4:0]          o_ex_rd_addr,
  output logic [CNT_W-1:0]    o_ill_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_OPB  = 5'd10;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic                vld;
    logic                insn_vld;
    logic                rd_wren;
    logic                mem_wren;
    logic                mem_rden;
    logic                br_un;
    logic                opa_sel;
    logic                opb_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          wb_sel;
    logic                is_branch;
    logic                is_jump;
    logic [4:0]          rd_addr;
  } ex_ctrl_t;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  logic       w_legal;
  logic       w_rd_wren;
  logic       w_mem_wren;
  logic       w_mem_rden;
  logic       w_br_un;
  logic       w_opa_sel;
  logic       w_opb_sel;
  logic [4:0] w_alu_op;
  logic [1:0] w_wb_sel;
  logic       w_is_branch;
  logic       w_is_jump;
  logic       w_rs1_en;
  logic       w_rs2_en;

  logic       w_hazard;
  logic       w_load;
  ex_ctrl_t   w_dec;
  ex_ctrl_t   r_ex;
  logic [CNT_W-1:0] r_ill_cnt;

  assign w_opcode = i_inst[6:0];
  assign w_rd     = i_inst[11:7];
  assign w_funct3 = i_inst[14:12];
  assign w_rs1    = i_inst[19:15];
  assign w_rs2    = i_inst[24:20];
  assign w_funct7 = i_inst[31:25];

  function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    w_legal     = 1'b0;
    w_rd_wren   = 1'b0;
    w_mem_wren  = 1'b0;
    w_mem_rden  = 1'b0;
    w_br_un     = 1'b0;
    w_opa_sel   = 1'b0;
    w_opb_sel   = 1'b0;
    w_alu_op    = ALU_ADD;
    w_wb_sel    = 2'b00;
    w_is_branch = 1'b0;
    w_is_jump   = 1'b0;
    w_rs1_en    = 1'b0;
    w_rs2_en    = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_legal = 1'b1; w_rd_wren = 1'b1; w_opb_sel = 1'b1;
        w_alu_op = ALU_OPB; w_wb_sel = 2'b01;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1; w_rd_wren = 1'b1; w_opa_sel = 1'b1; w_opb_sel = 1'b1;
        w_wb_sel = 2'b01;
      end
      OPC_JAL: begin
        w_legal = 1'b1; w_rd_wren = 1'b1; w_opa_sel = 1'b1; w_opb_sel = 1'b1;
        w_is_jump = 1'b1;
      end
      OPC_JALR: begin
        w_legal = (w_funct3 == 3'b000); w_rs1_en = 1'b1; w_rd_wren = 1'b1;
        w_opb_sel = 1'b1; w_is_jump = 1'b1;
      end
      // The ALU computes the branch target (pc + imm); the comparator gets rs1/rs2.
      OPC_BRANCH: begin
        w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
        w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_opa_sel = 1'b1; w_opb_sel = 1'b1;
        w_is_branch = 1'b1; w_br_un = w_funct3[1];
      end
      OPC_LOAD: begin
        w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
        w_rs1_en = 1'b1; w_rd_wren = 1'b1; w_mem_rden = 1'b1; w_opb_sel = 1'b1;
        w_wb_sel = 2'b10;
      end
      OPC_STORE: begin
        w_legal = (w_funct3[2] == 1'b0) && (w_funct3 != 3'b011);
        w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_mem_wren = 1'b1; w_opb_sel = 1'b1;
      end
      OPC_OPIMM: begin
        w_rs1_en = 1'b1; w_rd_wren = 1'b1; w_opb_sel = 1'b1; w_wb_sel = 2'b01;
        w_alu_op = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        case (w_funct3)
          3'b001:  w_legal = (w_funct7 == F7_BASE);
          3'b101:  w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
          default: w_legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_rd_wren = 1'b1; w_wb_sel = 2'b01;
        if (w_funct7 == F7_MUL) begin
          w_legal  = (ENABLE_M != 0);
          w_alu_op = {2'b10, w_funct3};
        end else begin
          w_legal  = (w_funct7 == F7_BASE) ||
                     ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
          w_alu_op = alu_from_funct3(w_funct3, w_funct7[5]);
        end
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal instructions travel down as valid-but-not-legal so EX can trap on them.
  always_comb begin
    w_dec           = '0;
    w_dec.vld       = 1'b1;
    w_dec.insn_vld  = w_legal;
    w_dec.rd_wren   = w_rd_wren & w_legal;
    w_dec.mem_wren  = w_mem_wren & w_legal;
    w_dec.mem_rden  = w_mem_rden & w_legal;
    w_dec.br_un     = w_br_un;
    w_dec.opa_sel   = w_opa_sel;
    w_dec.opb_sel   = w_opb_sel;
    w_dec.alu_op    = ALU_OP_W'(w_alu_op);
    w_dec.wb_sel    = w_wb_sel;
    w_dec.is_branch = w_is_branch & w_legal;
    w_dec.is_jump   = w_is_jump & w_legal;
    w_dec.rd_addr   = w_rd_wren ? w_rd : 5'd0;
  end

  assign w_hazard = r_ex.vld && r_ex.mem_rden && (r_ex.rd_addr != 5'd0) && i_id_vld &&
                    ((w_rs1_en && (w_rs1 == r_ex.rd_addr)) ||
                     (w_rs2_en && (w_rs2 == r_ex.rd_addr)));

  assign w_load = !i_flush && !i_stall && !w_hazard;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex <= '0;
    end else if (i_flush) begin
      r_ex <= '0;
    end else if (i_stall) begin
      r_ex <= r_ex;
    end else if (w_hazard || !i_id_vld) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_dec;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ill_cnt <= '0;
    end else if (w_load && i_id_vld && !w_legal && (r_ill_cnt != {CNT_W{1'b1}})) begin
      r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign o_hazard_stall = w_hazard;
  assign o_ex_vld       = r_ex.vld;
  assign o_ex_insn_vld  = r_ex.insn_vld;
  assign o_ex_rd_wren   = r_ex.rd_wren;
  assign o_ex_mem_wren  = r_ex.mem_wren;
  assign o_ex_mem_rden  = r_ex.mem_rden;
  assign o_ex_br_un     = r_ex.br_un;
  assign o_ex_opa_sel   = r_ex.opa_sel;
  assign o_ex_opb_sel   = r_ex.opb_sel;
  assign o_ex_alu_op    = r_ex.alu_op;
  assign o_ex_wb_sel    = r_ex.wb_sel;
  assign o_ex_is_branch = r_ex.is_branch;
  assign o_ex_is_jump   = r_ex.is_jump;
  assign o_ex_rd_addr   = r_ex.rd_addr;
  assign o_ill_cnt      = r_ill_cnt;

endmodule

// File: tb/tb_control_decode_stage.sv
// Directed bench for control_decode_stage: one instance with the M extension,
// one without it and with a 2-bit illegal counter, both driven by the same stimulus.
module tb_control_decode_stage;

  logic        clk;
  logic        rstN;
  logic [31:0] inst;
  logic        idVld;
  logic        stall;
  logic        flush;

  logic       mHazard, mVld, mInsnVld, mRdWren, mMemWren, mMemRden, mBrUn;
  logic       mOpaSel, mOpbSel, mIsBranch, mIsJump;
  logic [4:0] mAluOp;
  logic [1:0] mWbSel;
  logic [4:0] mRdAddr;
  logic [15:0] mIllCnt;

  logic       nHazard, nVld, nInsnVld, nRdWren, nMemWren, nMemRden, nBrUn;
  logic       nOpaSel, nOpbSel, nIsBranch, nIsJump;
  logic [4:0] nAluOp;
  logic [1:0] nWbSel;
  logic [4:0] nRdAddr;
  logic [1:0] nIllCnt;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_ADD6  = 32'h00228333;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_BLTU  = 32'h0020E063;
  localparam logic [31:0] I_BADSL = 32'h402091B3;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_LUI   = 32'h123453B7;
  localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;

  control_decode_stage #(.ENABLE_M(1), .ALU_OP_W(5), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_inst(inst), .i_id_vld(idVld),
    .i_stall(stall), .i_flush(flush),
    .o_hazard_stall(mHazard), .o_ex_vld(mVld), .o_ex_insn_vld(mInsnVld),
    .o_ex_rd_wren(mRdWren), .o_ex_mem_wren(mMemWren), .o_ex_mem_rden(mMemRden),
    .o_ex_br_un(mBrUn), .o_ex_opa_sel(mOpaSel), .o_ex_opb_sel(mOpbSel),
    .o_ex_alu_op(mAluOp), .o_ex_wb_sel(mWbSel), .o_ex_is_branch(mIsBranch),
    .o_ex_is_jump(mIsJump), .o_ex_rd_addr(mRdAddr), .o_ill_cnt(mIllCnt)
  );

  control_decode_stage #(.ENABLE_M(0), .ALU_OP_W(5), .CNT_W(2)) dutNoM (
    .i_clk(clk), .i_rst_n(rstN), .i_inst(inst), .i_id_vld(idVld),
    .i_stall(stall), .i_flush(flush),
    .o_hazard_stall(nHazard), .o_ex_vld(nVld), .o_ex_insn_vld(nInsnVld),
    .o_ex_rd_wren(nRdWren), .o_ex_mem_wren(nMemWren), .o_ex_mem_rden(nMemRden),
    .o_ex_br_un(nBrUn), .o_ex_opa_sel(nOpaSel), .o_ex_opb_sel(nOpbSel),
    .o_ex_alu_op(nAluOp), .o_ex_wb_sel(nWbSel), .o_ex_is_branch(nIsBranch),
    .o_ex_is_jump(nIsJump), .o_ex_rd_addr(nRdAddr), .o_ill_cnt(nIllCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] newInst, input logic newVld,
                               input logic newStall, input logic newFlush);
    inst  = newInst;
    idVld = newVld;
    stall = newStall;
    flush = newFlush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expCnt[5];
    expCnt = '{1, 2, 3, 3, 3};
    clk = 1'b0; rstN = 1'b0;
    inst = '0; idVld = 1'b0; stall = 1'b0; flush = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.vld", 32'(mVld), 0);
    checkOutput("rst.alu", 32'(mAluOp), 0);
    checkOutput("rst.mcnt", 32'(mIllCnt), 0);
    checkOutput("rst.ncnt", 32'(nIllCnt), 0);
    rstN = 1'b1;

    applyStimulus(I_ADD, 1, 0, 0); tick();
    checkOutput("add.vld", 32'(mVld), 1);
    checkOutput("add.insn", 32'(mInsnVld), 1);
    checkOutput("add.alu", 32'(mAluOp), 0);
    checkOutput("add.wren", 32'(mRdWren), 1);
    checkOutput("add.rd", 32'(mRdAddr), 3);
    checkOutput("add.wb", 32'(mWbSel), 1);
    checkOutput("add.opb", 32'(mOpbSel), 0);

    applyStimulus(I_SUB, 1, 0, 0); tick();
    checkOutput("sub.alu", 32'(mAluOp), 1);
    checkOutput("sub.rd", 32'(mRdAddr), 3);

    applyStimulus(I_LW, 1, 0, 0); tick();
    checkOutput("lw.rden", 32'(mMemRden), 1);
    checkOutput("lw.wb", 32'(mWbSel), 2);
    checkOutput("lw.rd", 32'(mRdAddr), 5);
    checkOutput("lw.opb", 32'(mOpbSel), 1);

    applyStimulus(I_ADD6, 1, 0, 0);
    checkOutput("hz.stall", 32'(mHazard), 1);
    tick();
    checkOutput("hz.bubble", 32'(mVld), 0);
    checkOutput("hz.clear", 32'(mHazard), 0);
    tick();
    checkOutput("hz.issue", 32'(mVld), 1);
    checkOutput("hz.rd", 32'(mRdAddr), 6);
    checkOutput("hz.rden", 32'(mMemRden), 0);

    applyStimulus(I_MUL, 1, 0, 0); tick();
    checkOutput("mul.alu", 32'(mAluOp), 16);
    checkOutput("mul.insn", 32'(mInsnVld), 1);
    checkOutput("mul.mcnt", 32'(mIllCnt), 0);
    checkOutput("mulN.vld", 32'(nVld), 1);
    checkOutput("mulN.insn", 32'(nInsnVld), 0);
    checkOutput("mulN.wren", 32'(nRdWren), 0);
    checkOutput("mulN.cnt", 32'(nIllCnt), 1);

    applyStimulus(I_ADD, 1, 1, 0); tick();
    checkOutput("stall.hold", 32'(mAluOp), 16);
    checkOutput("stall.vld", 32'(mVld), 1);

    applyStimulus(I_BEQ, 1, 0, 0); tick();
    checkOutput("beq.br", 32'(mIsBranch), 1);
    checkOutput("beq.rd", 32'(mRdAddr), 0);
    checkOutput("beq.wren", 32'(mRdWren), 0);
    checkOutput("beq.opa", 32'(mOpaSel), 1);
    checkOutput("beq.brun", 32'(mBrUn), 0);

    applyStimulus(I_ADD, 1, 1, 1); tick();
    checkOutput("flush.vld", 32'(mVld), 0);
    checkOutput("flush.br", 32'(mIsBranch), 0);

    applyStimulus(I_BLTU, 1, 0, 0); tick();
    checkOutput("bltu.brun", 32'(mBrUn), 1);

    applyStimulus(I_BADSL, 1, 0, 0); tick();
    checkOutput("badsl.vld", 32'(mVld), 1);
    checkOutput("badsl.insn", 32'(mInsnVld), 0);
    checkOutput("badsl.wren", 32'(mRdWren), 0);
    checkOutput("badsl.mcnt", 32'(mIllCnt), 1);
    checkOutput("badsl.ncnt", 32'(nIllCnt), 2);

    applyStimulus(I_JAL, 1, 0, 0); tick();
    checkOutput("jal.jump", 32'(mIsJump), 1);
    checkOutput("jal.wb", 32'(mWbSel), 0);
    checkOutput("jal.rd", 32'(mRdAddr), 1);

    applyStimulus(I_LUI, 1, 0, 0); tick();
    checkOutput("lui.alu", 32'(mAluOp), 10);
    checkOutput("lui.rd", 32'(mRdAddr), 7);

    applyStimulus(I_ADD, 0, 0, 0); tick();
    checkOutput("bubble.vld", 32'(mVld), 0);
    checkOutput("bubble.wren", 32'(mRdWren), 0);

    applyStimulus(I_ADD, 1, 0, 0); tick();
    checkOutput("pre.vld", 32'(mVld), 1);
    rstN = 1'b0;
    #1;
    checkOutput("arst.vld", 32'(mVld), 0);
    checkOutput("arst.rd", 32'(mRdAddr), 0);
    checkOutput("arst.wb", 32'(mWbSel), 0);
    checkOutput("arst.mcnt", 32'(mIllCnt), 0);
    rstN = 1'b1;

    for (int k = 0; k < 5; k++) begin
      applyStimulus(I_ONES, 1, 0, 0); tick();
      checkOutput($sformatf("sat.ncnt%0d", k), 32'(nIllCnt), 32'(expCnt[k]));
    end
    checkOutput("sat.mcnt", 32'(mIllCnt), 5);
    checkOutput("sat.insn", 32'(mInsnVld), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
